// File: rtl/axis_stream_checker_pkg.sv
// noc_test_pkg: shared types for the NoC test-harness sink.
//   err_bit_e   - bit positions inside err_flags
//   chk_state_e - packet checker FSM states
//   Header layout: sequence in [COUNT_WIDTH-1:0], length in the next HDR_LEN_W bits.
package noc_test_pkg;

  typedef enum logic [2:0] {
    ERR_SEQ   = 3'd0,
    ERR_DEST  = 3'd1,
    ERR_LEN   = 3'd2,
    ERR_INTLV = 3'd3,
    ERR_FIDX  = 3'd4
  } err_bit_e;

  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } chk_state_e;

  localparam int HDR_SEQ_LSB = 0;
  localparam int HDR_LEN_W   = 8;
  localparam int ERR_W       = 5;

endpackage

// File: rtl/axis_stream_checker_if.sv
// AXI-Stream bus bundle between a router egress port and the checker.
//   master: drives tvalid/tdata/tlast/tid/tdest, receives tready
//   slave : receives tvalid/tdata/tlast/tid/tdest, drives tready
interface axis_stream_checker_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 2
) ();
  import noc_test_pkg::*;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_stream_checker_lfsr.sv
// axis_lfsr_ready: random backpressure generator.
//   clk, rst    - clock, synchronous active-high reset
//   i_thresh    - ready probability = i_thresh/256; >= 256 means always ready
//   o_ready     - registered ready, independent of the stream's tvalid
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, steps every cycle.
module axis_lfsr_ready #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] i_thresh,
  output logic       o_ready
);
  import noc_test_pkg::*;

  logic [15:0] r_lfsr;
  logic        r_ready;
  logic [15:0] w_lfsr_nxt;

  // Right-shifting Galois form: feedback mask 0xB400 encodes taps 16,14,13,11.
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr  <= LFSR_SEED;
      r_ready <= 1'b0;
    end else begin
      r_lfsr  <= w_lfsr_nxt;
      r_ready <= ({1'b0, r_lfsr[7:0]} < i_thresh);
    end
  end

  assign o_ready = r_ready;
endmodule

// File: rtl/axis_stream_checker.sv
// axis_stream_checker: multi-flit AXI-Stream sink for one router egress port.
//   clk, rst            - clock, synchronous active-high reset
//   ticks               - free-running time base
//   ready_thresh        - backpressure probability (n/256, >=256 always ready)
//   axis_in             - AXIS slave (tready generated here)
//   recv_packets[NSRC]  - completed packets per tid
//   total_recv_packets  - completed packets; total_recv_flits - accepted flits
//   lat_min/max/sum     - header latency statistics (ticks - sent tick)
//   first_tick/last_tick- ticks at first header / at last packet end
//   err_flags           - sticky {flit_idx, interleave, length, dest, seq}; error = |err_flags
module axis_stream_checker
  import noc_test_pkg::*;
#(
  parameter int          TDATA_WIDTH = 512,
  parameter int          TDEST_WIDTH = 2,
  parameter int          TID_WIDTH   = 2,
  parameter int          TDEST       = 0,
  parameter int          COUNT_WIDTH = 32,
  parameter int          LAT_WIDTH   = 32,
  parameter int          MAX_FLITS   = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [TDATA_WIDTH/2-1:0]         ticks,
  input  logic [8:0]                       ready_thresh,
  axis_stream_checker_if.slave             axis_in,
  output logic [COUNT_WIDTH-1:0]           recv_packets [2**TID_WIDTH],
  output logic [COUNT_WIDTH-1:0]           total_recv_packets,
  output logic [COUNT_WIDTH-1:0]           total_recv_flits,
  output logic [LAT_WIDTH-1:0]             lat_min,
  output logic [LAT_WIDTH-1:0]             lat_max,
  output logic [LAT_WIDTH+COUNT_WIDTH-1:0] lat_sum,
  output logic [TDATA_WIDTH/2-1:0]         first_tick,
  output logic [TDATA_WIDTH/2-1:0]         last_tick,
  output logic [ERR_W-1:0]                 err_flags,
  output logic                             error
);
  localparam int NSRC = 2**TID_WIDTH;
  localparam int TH   = TDATA_WIDTH/2;
  localparam int SUMW = LAT_WIDTH + COUNT_WIDTH;

  function automatic logic [LAT_WIDTH-1:0] sat_lat(input logic [TH-1:0] d);
    if (|d[TH-1:LAT_WIDTH]) return '1;
    return d[LAT_WIDTH-1:0];
  endfunction

  chk_state_e                 r_state, w_state_nxt;
  logic [TID_WIDTH-1:0]       r_cur_tid;
  logic [HDR_LEN_W-1:0]       r_idx, r_len;
  logic [COUNT_WIDTH-1:0]     r_exp_seq [NSRC];
  logic [COUNT_WIDTH-1:0]     r_recv_packets [NSRC];
  logic [COUNT_WIDTH-1:0]     r_total_pkts, r_total_flits;
  logic [LAT_WIDTH-1:0]       r_lat_min, r_lat_max;
  logic [SUMW-1:0]            r_lat_sum;
  logic [TH-1:0]              r_first_tick, r_last_tick;
  logic                       r_first_seen;
  logic [ERR_W-1:0]           r_err;

  logic                       w_ready, w_acc, w_hdr_acc, w_pkt_end;
  logic [TID_WIDTH-1:0]       w_end_tid;
  logic [ERR_W-1:0]           w_err_set;
  logic [COUNT_WIDTH-1:0]     w_word;
  logic [HDR_LEN_W-1:0]       w_len, w_eff_len;
  logic                       w_len_bad, w_idx_end;
  logic [LAT_WIDTH-1:0]       w_lat;
  logic                       w_unused_bits;

  axis_lfsr_ready #(.LFSR_SEED(LFSR_SEED)) u_ready (
    .clk      (clk),
    .rst      (rst),
    .i_thresh (ready_thresh),
    .o_ready  (w_ready)
  );

  assign axis_in.tready = w_ready;
  assign w_acc          = axis_in.tvalid & w_ready;
  assign w_word         = axis_in.tdata[HDR_SEQ_LSB +: COUNT_WIDTH];
  assign w_len          = axis_in.tdata[COUNT_WIDTH +: HDR_LEN_W];
  assign w_len_bad      = (w_len == '0) || (w_len > HDR_LEN_W'(MAX_FLITS));
  assign w_eff_len      = w_len_bad ? HDR_LEN_W'(1) : w_len;
  assign w_lat          = sat_lat(ticks - axis_in.tdata[TDATA_WIDTH-1:TH]);
  // A degenerate L==1 body (header sent without tlast) ends on its first body flit.
  assign w_idx_end      = (r_idx >= r_len - HDR_LEN_W'(1));
  assign w_unused_bits  = ^axis_in.tdata[TH-1:COUNT_WIDTH+HDR_LEN_W];

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = '0;
    w_hdr_acc   = 1'b0;
    w_pkt_end   = 1'b0;
    w_end_tid   = r_cur_tid;
    if (w_acc) begin
      if (axis_in.tdest != TDEST_WIDTH'(TDEST)) w_err_set[ERR_DEST] = 1'b1;
      if (r_state == HDR) begin
        w_hdr_acc = 1'b1;
        w_end_tid = axis_in.tid;
        if (w_word != r_exp_seq[axis_in.tid]) w_err_set[ERR_SEQ] = 1'b1;
        if (w_len_bad || (axis_in.tlast != (w_eff_len == HDR_LEN_W'(1))))
          w_err_set[ERR_LEN] = 1'b1;
        // tlast, not the header length, decides where the packet ends.
        if (axis_in.tlast) w_pkt_end = 1'b1;
        else               w_state_nxt = BODY;
      end else begin
        if (axis_in.tid != r_cur_tid)          w_err_set[ERR_INTLV] = 1'b1;
        if (w_word != COUNT_WIDTH'(r_idx))     w_err_set[ERR_FIDX]  = 1'b1;
        if (axis_in.tlast != w_idx_end)        w_err_set[ERR_LEN]   = 1'b1;
        if (axis_in.tlast || w_idx_end) begin
          w_pkt_end   = 1'b1;
          w_state_nxt = HDR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= HDR;
      r_cur_tid     <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_total_pkts  <= '0;
      r_total_flits <= '0;
      r_lat_min     <= '1;
      r_lat_max     <= '0;
      r_lat_sum     <= '0;
      r_first_tick  <= '0;
      r_last_tick   <= '0;
      r_first_seen  <= 1'b0;
      r_err         <= '0;
      for (int i = 0; i < NSRC; i++) begin
        r_exp_seq[i]      <= '0;
        r_recv_packets[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_err_set;
      if (w_acc) r_total_flits <= r_total_flits + 1'b1;
      if (w_hdr_acc) begin
        // Always resync to the received sequence so one gap flags only once.
        r_exp_seq[axis_in.tid] <= w_word + 1'b1;
        if (w_lat < r_lat_min) r_lat_min <= w_lat;
        if (w_lat > r_lat_max) r_lat_max <= w_lat;
        r_lat_sum <= r_lat_sum + SUMW'(w_lat);
        if (!r_first_seen) begin
          r_first_tick <= ticks;
          r_first_seen <= 1'b1;
        end
        r_cur_tid <= axis_in.tid;
        r_idx     <= HDR_LEN_W'(1);
        r_len     <= w_eff_len;
      end else if (w_acc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_pkt_end) begin
        r_recv_packets[w_end_tid] <= r_recv_packets[w_end_tid] + 1'b1;
        r_total_pkts              <= r_total_pkts + 1'b1;
        r_last_tick               <= ticks;
      end
    end
  end

  assign recv_packets       = r_recv_packets;
  assign total_recv_packets = r_total_pkts;
  assign total_recv_flits   = r_total_flits;
  assign lat_min            = r_lat_min;
  assign lat_max            = r_lat_max;
  assign lat_sum            = r_lat_sum;
  assign first_tick         = r_first_tick;
  assign last_tick          = r_last_tick;
  assign err_flags          = r_err;
  assign error              = |r_err;
endmodule

// File: tb/tb_axis_stream_checker.sv
module tb_axis_stream_checker;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] ticks;
  logic [8:0]   thr;
  logic [31:0]  recv_packets [4];
  logic [31:0]  total_recv_packets, total_recv_flits, lat_min, lat_max;
  logic [63:0]  lat_sum;
  logic [255:0] first_tick, last_tick;
  logic [4:0]   err_flags;
  logic         error;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  axis_stream_checker_if #(.TDATA_WIDTH(512), .TID_WIDTH(2), .TDEST_WIDTH(2)) axis ();

  axis_stream_checker dut (
    .clk                (clk),
    .rst                (rst),
    .ticks              (ticks),
    .ready_thresh       (thr),
    .axis_in            (axis),
    .recv_packets       (recv_packets),
    .total_recv_packets (total_recv_packets),
    .total_recv_flits   (total_recv_flits),
    .lat_min            (lat_min),
    .lat_max            (lat_max),
    .lat_sum            (lat_sum),
    .first_tick         (first_tick),
    .last_tick          (last_tick),
    .err_flags          (err_flags),
    .error              (error)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] hdr(input int seq, input int len, input logic [255:0] sent);
    logic [511:0] d;
    d = '0;
    d[31:0]    = seq;
    d[39:32]   = len[7:0];
    d[511:256] = sent;
    return d;
  endfunction

  function automatic logic [511:0] bdy(input int k);
    logic [511:0] d;
    d = '0;
    d[31:0] = k;
    return d;
  endfunction

  task automatic send(input logic [1:0] tid, input logic [1:0] tdest,
                      input logic [511:0] data, input logic last);
    int w;
    @(negedge clk);
    axis.tvalid = 1'b1;
    axis.tid    = tid;
    axis.tdest  = tdest;
    axis.tdata  = data;
    axis.tlast  = last;
    w = 0;
    while (!axis.tready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) begin
      n_cmp++;
      n_err++;
      $error("FAIL tready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1 axis.tvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int rdy_cnt;
    rst         = 1'b1;
    ticks       = 256'd5;
    thr         = 9'd256;
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tlast  = 1'b0;
    axis.tid    = '0;
    axis.tdest  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tready", axis.tready, 1'b0);
    chk("rst_total", total_recv_packets, 0);
    chk("rst_flits", total_recv_flits, 0);
    chk("rst_lat_min", lat_min, 32'hFFFF_FFFF);
    chk("rst_lat_max", lat_max, 0);
    chk("rst_err", err_flags, 5'b00000);
    rst = 1'b0;

    // 1: four single-flit packets, tid 0
    for (int s = 0; s < 4; s++) send(2'd0, 2'd0, hdr(s, 1, 256'd5), 1'b1);
    chk("t1_total", total_recv_packets, 4);
    chk("t1_recv0", recv_packets[0], 4);
    chk("t1_flits", total_recv_flits, 4);
    chk("t1_error", error, 1'b0);

    // 2: three-flit packet, latency 7
    do_reset();
    ticks = 256'd17;
    send(2'd1, 2'd0, hdr(0, 3, 256'd10), 1'b0);
    send(2'd1, 2'd0, bdy(1), 1'b0);
    send(2'd1, 2'd0, bdy(2), 1'b1);
    chk("t2_lat_min", lat_min, 7);
    chk("t2_lat_max", lat_max, 7);
    chk("t2_lat_sum", lat_sum, 7);
    chk("t2_flits", total_recv_flits, 3);
    chk("t2_recv1", recv_packets[1], 1);
    chk("t2_total", total_recv_packets, 1);
    chk("t2_first", first_tick, 17);
    chk("t2_last", last_tick, 17);
    chk("t2_error", error, 1'b0);

    // 3: sequence gap on tid 0, then resync
    ticks = 256'd30;
    send(2'd0, 2'd0, hdr(0, 1, 256'd30), 1'b1);
    send(2'd0, 2'd0, hdr(1, 1, 256'd30), 1'b1);
    chk("t3_err_pre", err_flags, 5'b00000);
    send(2'd0, 2'd0, hdr(3, 1, 256'd30), 1'b1);
    chk("t3_err_gap", err_flags, 5'b00001);
    send(2'd0, 2'd0, hdr(4, 1, 256'd30), 1'b1);
    chk("t3_err_resync", err_flags, 5'b00001);
    chk("t3_recv0", recv_packets[0], 4);
    chk("t3_total", total_recv_packets, 5);
    chk("t3_first", first_tick, 17);
    chk("t3_last", last_tick, 30);

    // 4: early tlast on a 4-flit packet
    do_reset();
    send(2'd0, 2'd0, hdr(0, 4, 256'd30), 1'b0);
    send(2'd0, 2'd0, bdy(1), 1'b0);
    send(2'd0, 2'd0, bdy(2), 1'b1);
    chk("t4_err", err_flags, 5'b00100);
    chk("t4_total", total_recv_packets, 1);
    chk("t4_flits", total_recv_flits, 3);
    send(2'd0, 2'd0, hdr(1, 1, 256'd30), 1'b1);
    chk("t4_back_hdr_err", err_flags, 5'b00100);
    chk("t4_back_hdr_total", total_recv_packets, 2);

    // 5: interleave, dest and flit-index errors
    do_reset();
    send(2'd1, 2'd0, hdr(0, 3, 256'd30), 1'b0);
    send(2'd2, 2'd0, bdy(1), 1'b0);
    send(2'd1, 2'd0, bdy(2), 1'b1);
    chk("t5_intlv", err_flags, 5'b01000);
    chk("t5_recv1", recv_packets[1], 1);
    chk("t5_recv2", recv_packets[2], 0);
    send(2'd0, 2'd1, hdr(0, 1, 256'd30), 1'b1);
    chk("t5_dest", err_flags, 5'b01010);
    send(2'd0, 2'd0, hdr(1, 2, 256'd30), 1'b0);
    send(2'd0, 2'd0, bdy(5), 1'b1);
    chk("t5_fidx", err_flags, 5'b11010);
    chk("t5_total", total_recv_packets, 3);
    chk("t5_error", error, 1'b1);

    // 6: backpressure duty, then reset mid-body
    do_reset();
    thr = 9'd128;
    rdy_cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (axis.tready) rdy_cnt++;
    end
    chk("t6_duty_in_range", (rdy_cnt >= 4500 && rdy_cnt <= 5500), 1'b1);
    thr = 9'd256;
    send(2'd0, 2'd0, hdr(0, 3, 256'd30), 1'b0);
    send(2'd0, 2'd0, bdy(1), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_total", total_recv_packets, 0);
    chk("t6_rst_flits", total_recv_flits, 0);
    chk("t6_rst_error", error, 1'b0);
    chk("t6_rst_lat_min", lat_min, 32'hFFFF_FFFF);
    chk("t6_rst_tready", axis.tready, 1'b0);
    rst = 1'b0;
    send(2'd0, 2'd0, hdr(0, 1, 256'd30), 1'b1);
    chk("t6_clean_err", err_flags, 5'b00000);
    chk("t6_clean_total", total_recv_packets, 1);
    chk("t6_clean_recv0", recv_packets[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
